mcif_read_ig_bpt: RTL and testbench
===================================

# mcif_read_ig_bpt

Read-ingress request splitter ("bpt") for one MCIF read client. Accepts one DMA read request (32B-atom address and length), splits it into bursts of at most 8 atoms that never cross a 256B boundary, and tags first/last beats. Reserves latency-FIFO credits per burst. Feeds the per-source arbiter input pipe stage directly downstream via the bpt2arb_req valid/ready/pd bus.

## Interface
- LAT_DEPTH, 256: latency-FIFO depth in atoms; initial and maximum credit count.
- AXID, 4'd1: AXI ID inserted into every output burst.
- nvdla_core_clk  in  1  clock.
- nvdla_core_rstn  in  1  reset, asynchronous, active-low.
- dma2bpt_req_valid  in  1  request valid.
- dma2bpt_req_ready  out  1  request ready.
- dma2bpt_req_pd  in  79  [63:0] byte address (bits 4:0 ignored), [78:64] size in atoms minus 1.
- bpt2arb_req_valid  out  1  burst valid.
- bpt2arb_req_ready  in  1  burst ready from the arbiter pipe stage.
- bpt2arb_req_pd  out  75  [63:0] addr (bits 4:0 = 0), [66:64] len in atoms minus 1, [67] ftran, [68] ltran, [72:69] AXID, [74:73] 0.
- lat_credit_return  in  1  one atom of latency-FIFO space freed this cycle.

## Operation
- FSM has two states, IDLE and SPLIT. dma2bpt_req_ready = (state == IDLE). There is no same-cycle bypass.
- IDLE accept (valid && ready):
  - cur_addr <= {addr[63:5], 5'b0}.
  - remain <= size (atoms minus 1, 15 bits).
  - first <= 1.
  - Go to SPLIT.
- Burst sizing in SPLIT, combinational from registers only:
  - to_bnd = 8 - cur_addr[7:5], range 1..8.
  - beat = min(remain + 1, to_bnd), 4 bits.
  - last = (remain + 1 == beat).
- bpt2arb_req_valid = SPLIT && (credit >= beat).
- bpt2arb_req_pd fields:
  - addr = cur_addr.
  - len = beat - 1.
  - ftran = first.
  - ltran = last.
- On output handshake:
  - cur_addr <= cur_addr + beat*32, modulo 2^64.
  - remain <= remain - beat.
  - first <= 0.
  - If last, go to IDLE.
- Credit counter:
  - Width $clog2(LAT_DEPTH)+1; reset value LAT_DEPTH.
  - Each cycle: credit <= credit - (handshake ? beat : 0) + lat_credit_return. A simultaneous take and return nets in the same cycle.
  - A return while credit == LAT_DEPTH is an error. It is ignored (saturate) and flagged by an assertion.
- Once valid is asserted, pd is stable and valid stays high until the handshake. This holds because state changes only on handshake and credit only increases while waiting.
- Reset mid-operation: FSM goes to IDLE, credit to LAT_DEPTH, first/remain/cur_addr to 0, and the partial request is dropped.

## Timing
- Reset values:
  - dma2bpt_req_ready = 1.
  - bpt2arb_req_valid = 0.
  - bpt2arb_req_pd = 0, except the AXID field.
- A request accepted at edge N can present its first burst in cycle N+1, given sufficient credit.
- Bursts issue back-to-back, one per cycle, while ready and credit allow.
- After the last-beat handshake at edge M, dma2bpt_req_ready is high in cycle M+1. Each request therefore costs a minimum of (bursts + 1) cycles.
- A credit return at edge K is visible to the valid computation in cycle K+1.
- No combinational path from bpt2arb_req_ready to bpt2arb_req_valid/pd, or from dma2bpt_req_valid to dma2bpt_req_ready.

## Test plan
- Single atom: addr 0x1000, size 0 -> one burst, addr 0x1000, len 0, ftran = ltran = 1; ready returns the cycle after the handshake.
- Boundary split: addr 0x10E0, size 9 -> exactly three bursts, in order:
  - 0x10E0 len 0, ftran = 1.
  - 0x1100 len 7.
  - 0x1200 len 0, ltran = 1.
- Credit stall: LAT_DEPTH = 8, addr 0x0, size 15 -> burst 0x0 len 7 issues, then valid stays low. Pulse lat_credit_return for 8 cycles -> valid rises the cycle after the 8th return with 0x100 len 7; credit ends at 0.
- Backpressure: hold bpt2arb_req_ready = 0 for 5 cycles mid-request -> valid stays 1 and pd is unchanged every cycle; the burst issues on the first ready cycle.
- Address wrap: addr 0xFFFF_FFFF_FFFF_FFE0, size 1 -> two bursts, in order:
  - 0xFFFF_FFFF_FFFF_FFE0 len 0, ftran = 1.
  - 0x0 len 0, ltran = 1.
- Reset mid-operation: assert reset during SPLIT with remain = 20 -> outputs immediately go to reset values and credit = LAT_DEPTH. A new request after reset splits correctly with ftran = 1.

Source files
------------

// File: rtl/mcif_read_ig_bpt_if.sv
// Handshake buses around the read-ingress splitter.
//   dma2bpt_req_*  : DMA read request in (addr/size in 32B atoms).
//   bpt2arb_req_*  : split burst out to the arbiter input pipe stage.
// master = upstream/downstream environment, slave = the splitter.
interface mcif_read_ig_bpt_if;
  logic        dma2bpt_req_valid;
  logic        dma2bpt_req_ready;
  logic [78:0] dma2bpt_req_pd;
  logic        bpt2arb_req_valid;
  logic        bpt2arb_req_ready;
  logic [74:0] bpt2arb_req_pd;

  modport master (
    output dma2bpt_req_valid, dma2bpt_req_pd, bpt2arb_req_ready,
    input  dma2bpt_req_ready, bpt2arb_req_valid, bpt2arb_req_pd
  );
  modport slave (
    input  dma2bpt_req_valid, dma2bpt_req_pd, bpt2arb_req_ready,
    output dma2bpt_req_ready, bpt2arb_req_valid, bpt2arb_req_pd
  );
endinterface

// File: rtl/mcif_read_ig_bpt.sv
// Read-ingress request splitter for one MCIF read client.
// Takes one DMA read request, cuts it into bursts of up to 8 atoms that
// never cross a 256B boundary, tags first/last bursts, and only issues a
// burst when the latency FIFO has room for all of its atoms.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   bus (slave)                      : dma2bpt_req_* in, bpt2arb_req_* out
//   lat_credit_return                : one latency-FIFO atom freed this cycle
module mcif_read_ig_bpt #(
  parameter int         LAT_DEPTH = 256,
  parameter logic [3:0] AXID      = 4'd1
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  mcif_read_ig_bpt_if.slave    bus,
  input  logic                 lat_credit_return
);
  localparam int CW = $clog2(LAT_DEPTH) + 1;
  localparam int XW = (CW > 4) ? CW : 4;   // common width for credit vs beat

  typedef enum logic {IDLE, SPLIT} state_t;

  state_t        state_q, state_d;
  logic [58:0]   atom_q, atom_d;           // current 32B-atom address
  logic [14:0]   remain_q, remain_d;       // atoms left minus 1
  logic          first_q, first_d;
  logic [CW-1:0] credit_q, credit_d;

  logic [3:0]    to_bnd, beat;
  logic [15:0]   rem_p1;
  logic          last, split, out_vld, accept, hs, ret_ok;
  logic          unused_addr_lsb;

  assign unused_addr_lsb = ^bus.dma2bpt_req_pd[4:0];

  always_comb begin
    // burst size comes from registers only, so valid/pd never see ready
    to_bnd  = 4'd8 - {1'b0, atom_q[2:0]};
    rem_p1  = {1'b0, remain_q} + 16'd1;
    beat    = (rem_p1 < {12'd0, to_bnd}) ? rem_p1[3:0] : to_bnd;
    last    = (rem_p1 == {12'd0, beat});
    split   = (state_q == SPLIT);
    out_vld = split && (XW'(credit_q) >= XW'(beat));
    hs      = out_vld && bus.bpt2arb_req_ready;
    accept  = bus.dma2bpt_req_valid && (state_q == IDLE);
    // a return into a full counter is dropped rather than wrapping
    ret_ok  = lat_credit_return && (credit_q != CW'(LAT_DEPTH));

    state_d  = state_q;
    atom_d   = atom_q;
    remain_d = remain_q;
    first_d  = first_q;
    credit_d = credit_q - (hs ? CW'(beat) : CW'(0)) + (ret_ok ? CW'(1) : CW'(0));

    if (accept) begin
      atom_d   = bus.dma2bpt_req_pd[63:5];
      remain_d = bus.dma2bpt_req_pd[78:64];
      first_d  = 1'b1;
      state_d  = SPLIT;
    end else if (hs) begin
      atom_d   = atom_q + 59'(beat);
      remain_d = remain_q - 15'(beat);
      first_d  = 1'b0;
      if (last) state_d = IDLE;
    end
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q  <= IDLE;
      atom_q   <= '0;
      remain_q <= '0;
      first_q  <= 1'b0;
      credit_q <= CW'(LAT_DEPTH);
    end else begin
      state_q  <= state_d;
      atom_q   <= atom_d;
      remain_q <= remain_d;
      first_q  <= first_d;
      credit_q <= credit_d;
    end
  end

  assign bus.dma2bpt_req_ready = (state_q == IDLE);
  assign bus.bpt2arb_req_valid = out_vld;
  // pd is forced to zero (AXID aside) outside SPLIT so idle/reset output is clean
  assign bus.bpt2arb_req_pd = split
    ? {2'b00, AXID, last, first_q, 3'(beat - 4'd1), atom_q, 5'b0}
    : {2'b00, AXID, 69'd0};

  credit_overflow_a: assert property (@(posedge nvdla_core_clk) disable iff (!nvdla_core_rstn)
    !(lat_credit_return && credit_q == CW'(LAT_DEPTH)));
endmodule

// File: tb/tb_mcif_read_ig_bpt.sv
// Randomized + directed bench for mcif_read_ig_bpt. A queue-based model
// expands each accepted request into its expected bursts and tracks the
// latency credit as a plain count.
module tb_mcif_read_ig_bpt;
  localparam int         LAT  = 8;
  localparam logic [3:0] AXID = 4'd1;
  localparam logic [74:0] RST_PD = {2'b00, AXID, 69'd0};

  logic clk = 1'b0, rstn = 1'b0, ret = 1'b0;
  always #5 clk = ~clk;

  mcif_read_ig_bpt_if ifc();
  mcif_read_ig_bpt #(.LAT_DEPTH(LAT), .AXID(AXID)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rstn(rstn),
    .bus(ifc.slave), .lat_credit_return(ret)
  );

  int errs = 0, checks = 0;
  task automatic chk(string tag, logic [79:0] obs, logic [79:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  typedef struct { logic [74:0] pd; int beat; } burst_t;
  burst_t      q[$];
  logic [74:0] got[$];
  int          cred_m = LAT;
  bit          hold = 0;
  logic [74:0] hold_pd;

  function automatic logic [74:0] mk(logic [63:0] a, int len, bit f, bit l);
    return {2'b00, AXID, l, f, 3'(len), a};
  endfunction

  // expand a request: walk atoms, never crossing a 256B line, max 8 per burst
  function automatic void add_req(logic [63:0] addr, int size);
    logic [63:0] a;
    int n, room, b;
    bit f;
    burst_t e;
    a = addr & ~64'h1F; n = size + 1; f = 1;
    while (n > 0) begin
      room = 8 - int'((a >> 5) % 8);
      b = (n < room) ? n : room;
      e.pd = mk(a, b - 1, f, n == b); e.beat = b;
      q.push_back(e);
      a = a + 64'(b) * 64'd32; n -= b; f = 0;
    end
  endfunction

  // monitor: sample mid-cycle, check, then advance the model by this cycle's events
  always @(negedge clk) begin
    bit ev;
    if (!rstn) begin
      q.delete(); cred_m = LAT; hold = 0;
      chk("rst_ready", ifc.dma2bpt_req_ready, 1);
      chk("rst_valid", ifc.bpt2arb_req_valid, 0);
      chk("rst_pd", ifc.bpt2arb_req_pd, RST_PD);
      chk("rst_credit", dut.credit_q, LAT);
    end else begin
      ev = (q.size() > 0) && (cred_m >= q[0].beat);
      chk("ready", ifc.dma2bpt_req_ready, q.size() == 0);
      chk("valid", ifc.bpt2arb_req_valid, ev);
      chk("credit", dut.credit_q, cred_m);
      if (hold) chk("hold_pd", ifc.bpt2arb_req_pd, hold_pd);
      if (ifc.bpt2arb_req_valid && q.size() > 0) chk("pd", ifc.bpt2arb_req_pd, q[0].pd);
      if (ifc.bpt2arb_req_valid && ifc.bpt2arb_req_ready && q.size() > 0) begin
        got.push_back(ifc.bpt2arb_req_pd);
        cred_m -= q[0].beat;
        void'(q.pop_front());
      end
      hold = ifc.bpt2arb_req_valid && !ifc.bpt2arb_req_ready;
      hold_pd = ifc.bpt2arb_req_pd;
      if (ret) cred_m++;
      if (ifc.dma2bpt_req_valid && ifc.dma2bpt_req_ready)
        add_req(ifc.dma2bpt_req_pd[63:0], int'(ifc.dma2bpt_req_pd[78:64]));
    end
  end

  int rdy_mode = 1;   // 0 low, 1 high, 2 random
  int ret_mode = 0;   // 0 none, 1 random, 2 whenever room
  task automatic drive;
    ifc.bpt2arb_req_ready = (rdy_mode == 2) ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
    ret = (cred_m < LAT) && (ret_mode == 2 || (ret_mode == 1 && $urandom_range(0, 1) == 1));
  endtask

  task automatic cyc;
    @(posedge clk); #1; drive();
  endtask

  task automatic send(logic [63:0] a, int sz);
    int n = 0;
    while (!ifc.dma2bpt_req_ready && n < 2000) begin cyc(); n++; end
    if (n >= 2000) chk("send_timeout", 1, 0);
    ifc.dma2bpt_req_valid = 1'b1;
    ifc.dma2bpt_req_pd = {15'(sz), a};
    cyc();
    ifc.dma2bpt_req_valid = 1'b0;
    ifc.dma2bpt_req_pd = 79'({$urandom(), $urandom(), $urandom()});
  endtask

  // finish outstanding bursts and refill credit
  task automatic drain;
    int n = 0;
    rdy_mode = 1; ret_mode = 2; drive();
    while ((q.size() > 0 || cred_m < LAT || !ifc.dma2bpt_req_ready) && n < 5000) begin cyc(); n++; end
    if (n >= 5000) chk("drain_timeout", 1, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [63:0] a;
    ifc.dma2bpt_req_valid = 1'b0;
    ifc.dma2bpt_req_pd = '0;
    ifc.bpt2arb_req_ready = 1'b1;
    repeat (3) cyc();
    rstn = 1'b1;

    // single atom
    rdy_mode = 1; ret_mode = 0; got.delete();
    send(64'h1000, 0);
    chk("t1_busy", ifc.dma2bpt_req_ready, 0);
    cyc();
    chk("t1_ready_back", ifc.dma2bpt_req_ready, 1);
    chk("t1_cnt", got.size(), 1);
    if (got.size() == 1) chk("t1_b0", got[0], mk(64'h1000, 0, 1, 1));
    drain();

    // 256B boundary split
    got.delete();
    send(64'h10E0, 9);
    drain();
    chk("t2_cnt", got.size(), 3);
    if (got.size() == 3) begin
      chk("t2_b0", got[0], mk(64'h10E0, 0, 1, 0));
      chk("t2_b1", got[1], mk(64'h1100, 7, 0, 0));
      chk("t2_b2", got[2], mk(64'h1200, 0, 0, 1));
    end

    // credit stall
    ret_mode = 0; got.delete();
    send(64'h0, 15);
    cyc();
    repeat (3) begin chk("t3_stall_low", ifc.bpt2arb_req_valid, 0); cyc(); end
    ret_mode = 2; rdy_mode = 0; drive();
    n = 0;
    while (!ifc.bpt2arb_req_valid && n < 20) begin cyc(); n++; end
    chk("t3_stall_cycles", n, 8);
    chk("t3_pd", ifc.bpt2arb_req_pd, mk(64'h100, 7, 0, 1));
    ret_mode = 0; rdy_mode = 1; drive();
    cyc();
    chk("t3_credit_end", dut.credit_q, 0);
    chk("t3_cnt", got.size(), 2);
    drain();

    // backpressure mid-request
    ret_mode = 0; got.delete();
    send(64'hE0, 3);
    rdy_mode = 0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      chk("t4_valid_held", ifc.bpt2arb_req_valid, 1);
      if (i == 4) rdy_mode = 1;
      cyc();
    end
    cyc();
    chk("t4_cnt", got.size(), 2);
    if (got.size() == 2) begin
      chk("t4_b0", got[0], mk(64'hE0, 0, 1, 0));
      chk("t4_b1", got[1], mk(64'h100, 2, 0, 1));
    end
    drain();

    // address wrap
    got.delete();
    send(64'hFFFF_FFFF_FFFF_FFE0, 1);
    drain();
    chk("t5_cnt", got.size(), 2);
    if (got.size() == 2) begin
      chk("t5_b0", got[0], mk(64'hFFFF_FFFF_FFFF_FFE0, 0, 1, 0));
      chk("t5_b1", got[1], mk(64'h0, 0, 0, 1));
    end

    // reset mid-operation
    ret_mode = 0;
    send(64'h0, 28);
    cyc(); cyc();
    chk("t6_remain", dut.remain_q, 20);
    rstn = 1'b0;
    #1;
    chk("t6_ready", ifc.dma2bpt_req_ready, 1);
    chk("t6_valid", ifc.bpt2arb_req_valid, 0);
    chk("t6_pd", ifc.bpt2arb_req_pd, RST_PD);
    chk("t6_credit", dut.credit_q, LAT);
    cyc(); cyc();
    rstn = 1'b1;
    got.delete();
    send(64'h2040, 9);
    drain();
    chk("t6_cnt", got.size(), 2);
    if (got.size() == 2) begin
      chk("t6_b0", got[0], mk(64'h2040, 5, 1, 0));
      chk("t6_b1", got[1], mk(64'h2100, 3, 0, 1));
    end

    // random traffic
    rdy_mode = 2; ret_mode = 1;
    for (int i = 0; i < 60; i++) begin
      a = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) a[63:12] = '1;
      send(a, $urandom_range(0, 40));
      rdy_mode = 2; ret_mode = 1;
    end
    drain();
    chk("end_idle", ifc.dma2bpt_req_ready, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
